// File: rtl/button_scan_scheduler_if.sv
// Button-side bus of button_scan_scheduler: raw inputs in, clean levels and events out.
// With BUTTON_SCAN_HOLD_EN defined the bus also carries the long-press level held.
interface button_scan_scheduler_if #(
  parameter int N = 4
);
  logic [N-1:0] bouncy_in;
  logic [N-1:0] debounced_out;
  logic [N-1:0] pressed;
  logic [N-1:0] released;
  logic         scan_busy;
  logic         overrun;
  logic         state_dbg;
`ifdef BUTTON_SCAN_HOLD_EN
  logic [N-1:0] held;

  modport master (
    output bouncy_in,
    input  debounced_out, pressed, released, scan_busy, overrun, state_dbg, held
  );
  modport slave (
    input  bouncy_in,
    output debounced_out, pressed, released, scan_busy, overrun, state_dbg, held
  );
`else
  modport master (
    output bouncy_in,
    input  debounced_out, pressed, released, scan_busy, overrun, state_dbg
  );
  modport slave (
    input  bouncy_in,
    output debounced_out, pressed, released, scan_busy, overrun, state_dbg
  );
`endif
endinterface

// File: rtl/button_scan_scheduler.sv
// Shared-engine debouncer: one prescaler strobe starts a round-robin scan of N channels.
// Optional long-press detection is enabled by defining BUTTON_SCAN_HOLD_EN.
module button_scan_scheduler #(
  parameter int N            = 4,
  parameter int SCAN_TICKS   = 12000,
  parameter int STABLE_COUNT = 8
`ifdef BUTTON_SCAN_HOLD_EN
  , parameter int HOLD_SCANS = 500
`endif
) (
  input logic                    clk,
  input logic                    rst,
  button_scan_scheduler_if.slave bus
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = $clog2(SCAN_TICKS);
  localparam int SW = $clog2(STABLE_COUNT + 1);
  localparam logic [CW-1:0] LAST_CH   = CW'(N - 1);
  localparam logic [PW-1:0] LAST_TICK = PW'(SCAN_TICKS - 1);
  localparam logic [SW-1:0] ACCEPT    = SW'(STABLE_COUNT - 1);

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  state_t        state;
  logic [N-1:0]  sync1, sync2;
  logic [N-1:0]  dbo, pr, rl;
  logic [PW-1:0] presc;
  logic [CW-1:0] ch;
  logic [SW-1:0] cnt [N];
  logic          busy, ovr;
  logic          strobe, differ, accept;

  assign strobe = (presc == LAST_TICK);
  assign differ = (sync2[ch] != dbo[ch]);
  assign accept = differ && (cnt[ch] == ACCEPT);

  // Synchronizer and free-running prescaler, independent of the FSM state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
      presc <= '0;
    end else begin
      sync1 <= bus.bouncy_in;
      sync2 <= sync1;
      presc <= strobe ? '0 : presc + 1'b1;
    end
  end

`ifdef BUTTON_SCAN_HOLD_EN
  localparam int HW = $clog2(HOLD_SCANS + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_SCANS);
  logic [HW-1:0] hold_cnt [N];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      ch    <= '0;
      dbo   <= '0;
      pr    <= '0;
      rl    <= '0;
      busy  <= 1'b0;
      ovr   <= 1'b0;
      for (int i = 0; i < N; i++) cnt[i] <= '0;
`ifdef BUTTON_SCAN_HOLD_EN
      for (int i = 0; i < N; i++) hold_cnt[i] <= '0;
`endif
    end else begin
      pr <= '0;
      rl <= '0;
      case (state)
        IDLE: begin
          if (strobe) begin
            state <= SCAN;
            busy  <= 1'b1;
            ch    <= '0;
          end
        end
        SCAN: begin
          // A strobe during a scan is dropped; it only flags a too-short SCAN_TICKS.
          if (strobe) ovr <= 1'b1;
          if (!differ) begin
            cnt[ch] <= '0;
          end else if (accept) begin
            dbo[ch] <= ~dbo[ch];
            cnt[ch] <= '0;
            pr[ch]  <= ~dbo[ch];
            rl[ch]  <= dbo[ch];
          end else begin
            cnt[ch] <= cnt[ch] + 1'b1;
          end
`ifdef BUTTON_SCAN_HOLD_EN
          if (dbo[ch] && !accept) begin
            if (hold_cnt[ch] != HOLD_MAX) hold_cnt[ch] <= hold_cnt[ch] + 1'b1;
          end else begin
            hold_cnt[ch] <= '0;
          end
`endif
          if (ch == LAST_CH) begin
            state <= IDLE;
            busy  <= 1'b0;
            ch    <= '0;
          end else begin
            ch <= ch + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.debounced_out = dbo;
  assign bus.pressed       = pr;
  assign bus.released      = rl;
  assign bus.scan_busy     = busy;
  assign bus.overrun       = ovr;
  assign bus.state_dbg     = (state == SCAN);

`ifdef BUTTON_SCAN_HOLD_EN
  always_comb begin
    bus.held = '0;
    for (int i = 0; i < N; i++) bus.held[i] = (hold_cnt[i] == HOLD_MAX);
  end
`endif
endmodule

// File: tb/tb_button_scan_scheduler.sv
// Randomized bench for button_scan_scheduler: a sample-sequence reference model predicts
// press/release events into a queue that a negedge monitor pops and compares.
module tb_button_scan_scheduler;
  localparam int NCH = 4;
  localparam int ST  = 10;
  localparam int SC  = 3;
  localparam int HS  = 5;
  localparam int W   = 32;

  logic clk;
  logic rst;

  button_scan_scheduler_if #(.N(NCH)) bus ();
  button_scan_scheduler_if #(.N(NCH)) bus2 ();

  button_scan_scheduler #(.N(NCH), .SCAN_TICKS(ST), .STABLE_COUNT(SC)
`ifdef BUTTON_SCAN_HOLD_EN
    , .HOLD_SCANS(HS)
`endif
  ) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  // Too-short strobe period: the second strobe lands inside the first scan.
  button_scan_scheduler #(.N(NCH), .SCAN_TICKS(4), .STABLE_COUNT(SC)
`ifdef BUTTON_SCAN_HOLD_EN
    , .HOLD_SCANS(HS)
`endif
  ) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Scoreboard state
  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check_eq(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference model: edge count since reset, delayed input samples, per-channel
  // accepted level, run length of differing samples and scans spent high.
  int e;
  logic [NCH-1:0] b_d1, b_d2, lvl;
  int run [NCH];
  int hold [NCH];
  int press_edge [NCH];
  int held_rise_edge;

  initial begin : model
    int c;
    logic old;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        e = 0;
        b_d1 = '0;
        b_d2 = '0;
        lvl = '0;
        for (int i = 0; i < NCH; i++) begin
          run[i] = 0;
          hold[i] = 0;
        end
        exp_q.delete();
      end else begin
        e++;
        // Visit of channel c registers at edge ST+1+c of every scan period.
        if (e > ST && ((e - 1 - ST) % ST) < NCH) begin
          c = (e - 1 - ST) % ST;
          old = lvl[c];
          if (b_d2[c] == lvl[c]) begin
            run[c] = 0;
          end else begin
            run[c]++;
            if (run[c] == SC) begin
              lvl[c] = ~lvl[c];
              run[c] = 0;
              exp_q.push_back({e[26:0], c[3:0], lvl[c]});
            end
          end
          if (old && lvl[c]) hold[c] = (hold[c] < HS) ? hold[c] + 1 : HS;
          else hold[c] = 0;
        end
        b_d2 = b_d1;
        b_d1 = bus.bouncy_in;
      end
    end
  end

  // Monitor
  initial begin : monitor
    logic [W-1:0] got, item;
    logic [NCH-1:0] pulses;
    logic [NCH-1:0] held_exp;
    int busy_exp;
    forever begin
      @(negedge clk);
      if (rst) begin
        while (exp_q.size() > 0 && int'(exp_q[0][31:5]) < e) begin
          check_eq("event_by_edge", e, int'(exp_q[0][31:5]));
          item = exp_q.pop_front();
        end
        pulses = bus.pressed | bus.released;
        if (pulses != '0) begin
          check_eq("one_pulse_per_cycle", $countones(pulses), 1);
          for (int c = 0; c < NCH; c++) begin
            if (pulses[c]) begin
              got = {e[26:0], c[3:0], bus.pressed[c]};
              if (bus.pressed[c]) press_edge[c] = e;
              if (exp_q.size() == 0) begin
                check_eq("unexpected_pulse_ch", c, -1);
              end else begin
                item = exp_q.pop_front();
                check_eq("event", got, item);
              end
            end
          end
        end
        check_eq("debounced_out", bus.debounced_out, lvl);
        busy_exp = (e >= ST && ((e - ST) % ST) < NCH) ? 1 : 0;
        check_eq("scan_busy", bus.scan_busy, busy_exp);
        check_eq("state_dbg", bus.state_dbg, busy_exp);
        check_eq("overrun", bus.overrun, 0);
        if (e == 7) check_eq("overrun_short_before", bus2.overrun, 0);
        if (e == 8) check_eq("overrun_short_after", bus2.overrun, 1);
`ifdef BUTTON_SCAN_HOLD_EN
        for (int c = 0; c < NCH; c++) held_exp[c] = (hold[c] == HS);
        check_eq("held", bus.held, held_exp);
        if (bus.held[0] && held_rise_edge < 0) held_rise_edge = e;
`else
        held_exp = '0;
`endif
      end
    end
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic [NCH-1:0] v, input int n);
    bus.bouncy_in = v;
    tick(n);
  endtask

  task automatic check_all_clear(input string tag);
    check_eq({tag, "_debounced"}, bus.debounced_out, 0);
    check_eq({tag, "_pressed"}, bus.pressed, 0);
    check_eq({tag, "_released"}, bus.released, 0);
    check_eq({tag, "_scan_busy"}, bus.scan_busy, 0);
    check_eq({tag, "_overrun"}, bus.overrun, 0);
    check_eq({tag, "_overrun_short"}, bus2.overrun, 0);
`ifdef BUTTON_SCAN_HOLD_EN
    check_eq({tag, "_held"}, bus.held, 0);
`endif
  endtask

  // Stimulus
  initial begin : stimulus
    int found;
    logic [NCH-1:0] v;
    rst = 1'b0;
    bus.bouncy_in = '1;
    bus2.bouncy_in = '0;
    held_rise_edge = -1;
    for (int i = 0; i < NCH; i++) press_edge[i] = -1;
    tick(3);
    check_all_clear("reset");
    bus.bouncy_in = '0;
    rst = 1'b1;

    // Clean press on channel 2
    drive(4'b0100, 60);

    // Bounce on channel 1, then settle high
    v = 4'b0100;
    for (int t = 0; t < 100; ) begin
      int d;
      d = $urandom_range(1, 15);
      v[1] = ~v[1];
      drive(v, d);
      t += d;
    end
    v[1] = 1'b1;
    drive(v, 60);

    // Release channel 2
    drive(4'b0010, 60);

    // Random multi-channel activity
    for (int k = 0; k < 25; k++) drive(4'($urandom_range(0, 15)), $urandom_range(3, 50));

    // Asynchronous reset during the visit to channel 1 while channel 3 has two differing samples
    drive(4'b0010, 70);
    bus.bouncy_in = 4'b1010;
    found = 0;
    for (int i = 0; i < 300 && found == 0; i++) begin
      @(negedge clk);
      if (run[3] == 2 && e >= ST && ((e - ST) % ST) == 1) found = 1;
    end
    check_eq("midscan_setup_found", found, 1);
    #2 rst = 1'b0;
    #1 check_all_clear("midscan_reset");
    for (int i = 0; i < NCH; i++) press_edge[i] = -1;
    tick(2);
    rst = 1'b1;
    tick(60);
    check_eq("fresh_accept_edge_ch1", press_edge[1], 3 * ST + 2);
    check_eq("fresh_accept_edge_ch3", press_edge[3], 3 * ST + 4);

    // Long press on channel 0
    drive(4'b0001, 120);
`ifdef BUTTON_SCAN_HOLD_EN
    check_eq("held0_after_long_press", bus.held[0], 1);
    check_eq("held0_rise_delay", held_rise_edge - press_edge[0], HS * ST);
`endif
    drive(4'b0000, 60);

    check_eq("queue_drained", exp_q.size(), 0);
    check_eq("final_debounced", bus.debounced_out, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/button_scan_scheduler.md
Name: button_scan_scheduler

Overview:
- Debounces N mechanical inputs with one shared sampling engine instead of N free-running debouncers.
- A single prescaler generates a scan strobe. On each strobe a small FSM visits the channels round-robin, one per clock cycle, and updates a per-channel stability counter.
- Emits clean levels plus one-cycle press/release event pulses.
- Sits between board buttons and user logic; all outputs are in the clk domain.

Parameters:
- N, 4, number of input channels (1..16).
- SCAN_TICKS, 12000, clock cycles between scan strobes (1 ms at 12 MHz); must be >= N+2.
- STABLE_COUNT, 8, consecutive scans a new level must persist before it is accepted (>= 1).
- HOLD_SCANS, 500, scans a channel must stay debounced-high before held[] asserts (optional feature only).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- bouncy_in  input  N  raw asynchronous button levels.
- debounced_out  output  N  accepted stable levels.
- pressed  output  N  one-cycle pulse when a channel's debounced_out rises.
- released  output  N  one-cycle pulse when a channel's debounced_out falls.
- scan_busy  output  1  high while the FSM is in SCAN.
- overrun  output  1  sticky; set if a strobe arrives while scan_busy.
- held  output  N  long-press level (BUTTON_SCAN_HOLD_EN only).

Behaviour:
- Reset (rst=0, asynchronous): all outputs, synchronizers, prescaler, channel index and per-channel counters go to 0; FSM goes to IDLE. Reset asserted mid-scan aborts the scan immediately; no pulses are emitted afterwards.
- Synchronizer: 2-FF per channel on bouncy_in. The FSM reads only the synchronized value sync[ch].
- Prescaler:
  - Counts 0..SCAN_TICKS-1 and wraps.
  - strobe=1 for exactly the cycle in which the count equals SCAN_TICKS-1.
  - Free-runs in both FSM states.
- FSM states IDLE and SCAN:
  - IDLE -> SCAN on strobe, with ch=0.
  - In SCAN, ch increments every cycle; ch==N-1 -> IDLE next cycle.
  - A strobe in cycle k gives visits to channels 0..N-1 in cycles k+1..k+N. scan_busy is high for cycles k+1..k+N.
- Per-channel update during visit of ch (registered; results visible the following cycle):
  - If sync[ch]==debounced_out[ch]: cnt[ch] <= 0.
  - Else if cnt[ch]==STABLE_COUNT-1: toggle debounced_out[ch], set cnt[ch] <= 0, and pulse pressed[ch] (new level 1) or released[ch] (new level 0).
  - Else: cnt[ch] <= cnt[ch]+1.
- Counter width is $clog2(STABLE_COUNT+1); the counter never exceeds STABLE_COUNT-1.
- Any agreeing sample resets the count, so bounce restarts the acceptance window.
- Non-visited channels hold their state. pressed/released are zero except in the single cycle after the accepting visit. At most one channel's pulse fires per cycle.
- STABLE_COUNT=1: the first differing sample is accepted.
- Overrun: a strobe while scan_busy=1 is dropped (no new scan starts, the current scan finishes) and overrun latches 1 until reset. This cannot occur when SCAN_TICKS >= N+2; it is a parameter-error detector.
- Latency from a clean input edge to debounced_out change: 2 sync cycles + wait for next strobe + (STABLE_COUNT-1)*SCAN_TICKS + ch + 2 cycles.

Optional Feature:
- Macro: BUTTON_SCAN_HOLD_EN.
- When defined:
  - Each channel has a hold counter, $clog2(HOLD_SCANS+1) bits.
  - On each visit with debounced_out[ch]=1 (value before this visit's update), the counter increments, saturating at HOLD_SCANS.
  - held[ch]=1 while the counter equals HOLD_SCANS.
  - On released[ch] or debounced_out[ch]=0 the counter clears and held[ch] drops in the same cycle as released.
- When not defined: no held port and no hold counters; all other behaviour is identical.

Test Plan (N=4, SCAN_TICKS=10, STABLE_COUNT=3, HOLD_SCANS=5):
- Reset: hold rst=0 for 3 cycles with bouncy_in=4'hF -> all outputs 0. After release, first strobe in cycle 9 after reset; scan_busy high for 4 cycles.
- Clean press: bouncy_in[2] 0->1 and held -> debounced_out[2] rises after the 3rd differing scan; pressed[2] high exactly 1 cycle (at visit cycle+1); no other channel changes.
- Bounce: toggle bouncy_in[1] randomly every 1-15 cycles for 100 cycles, then hold at 1 -> no pressed[1] during bounce unless 3 consecutive samples agree; exactly one pressed[1] after settling, 3 scans later.
- Release: from debounced 1, drop bouncy_in[2] -> released[2] one-cycle pulse after 3 scans; pressed stays 0.
- Async reset mid-scan: assert rst during the visit to channel 1 while cnt[3]=2 -> outputs clear immediately; after release, a full 3 fresh scans are needed before any acceptance.
- Hold (macro defined): keep bouncy_in[0]=1 -> held[0] rises 5 scans after pressed[0]. Release input -> held[0] falls with released[0]. Separate build with SCAN_TICKS=4, N=4 -> overrun=1 after the second strobe.
